// File: rtl/image_pkg.sv
// Shared definitions for the pixel-processing stage: operation encodings,
// luma constants, FSM state type and the default channel width.
package image_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] MODE_BYPASS   = 3'd0;
  localparam logic [2:0] MODE_BRIGHTEN = 3'd1;
  localparam logic [2:0] MODE_DARKEN   = 3'd2;
  localparam logic [2:0] MODE_INVERT   = 3'd3;
  localparam logic [2:0] MODE_THRESH   = 3'd4;
  localparam logic [2:0] MODE_GREY     = 3'd5;

  // Luma approximation (r + 2g + b) / 4: two guard bits hold the sum of 4*M.
  localparam int LUMA_GUARD = 2;
  localparam int LUMA_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/image_pixel_op.sv
// Combinational per-pixel operator: applies the selected mode to one RGB
// pixel. Reserved modes fall through to bypass.
module image_pixel_op
  import image_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b
);

  localparam logic [DATA_W-1:0] MAXV = '1;

  function automatic logic [DATA_W-1:0] sat_add(logic [DATA_W-1:0] x, logic [DATA_W-1:0] v);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, v};
    return s[DATA_W] ? MAXV : s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_sub(logic [DATA_W-1:0] x, logic [DATA_W-1:0] v);
    return (x > v) ? (x - v) : '0;
  endfunction

  logic [DATA_W+LUMA_GUARD-1:0] luma_sum;
  logic [DATA_W-1:0]            luma;
  logic [DATA_W-1:0]            thr;

  assign luma_sum = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
  assign luma     = luma_sum[DATA_W+LUMA_SHIFT-1:LUMA_SHIFT];
  assign thr      = (luma >= value) ? MAXV : '0;

  always_comb begin
    out_r = in_r;
    out_g = in_g;
    out_b = in_b;
    case (mode)
      MODE_BRIGHTEN: begin
        out_r = sat_add(in_r, value);
        out_g = sat_add(in_g, value);
        out_b = sat_add(in_b, value);
      end
      MODE_DARKEN: begin
        out_r = sat_sub(in_r, value);
        out_g = sat_sub(in_g, value);
        out_b = sat_sub(in_b, value);
      end
      MODE_INVERT: begin
        out_r = MAXV - in_r;
        out_g = MAXV - in_g;
        out_b = MAXV - in_b;
      end
      MODE_THRESH: begin
        out_r = thr;
        out_g = thr;
        out_b = thr;
      end
      MODE_GREY: begin
        out_r = luma;
        out_g = luma;
        out_b = luma;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/image_pixel_proc.sv
// Pixel-processing stage: PIX_PER_BEAT pixels per beat, one registered output
// slot with valid/ready, raster tracking and frame markers.
module image_pixel_proc
  import image_pkg::*;
#(
  parameter int PIX_PER_BEAT = 2,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IMG_W        = 768,
  parameter int IMG_H        = 512
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic                           start,
  input  logic [2:0]                     mode,
  input  logic [DATA_W-1:0]              value,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIX_PER_BEAT*DATA_W-1:0] in_r,
  input  logic [PIX_PER_BEAT*DATA_W-1:0] in_g,
  input  logic [PIX_PER_BEAT*DATA_W-1:0] in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PIX_PER_BEAT*DATA_W-1:0] out_r,
  output logic [PIX_PER_BEAT*DATA_W-1:0] out_g,
  output logic [PIX_PER_BEAT*DATA_W-1:0] out_b,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t state, state_nxt;

  logic [2:0]        mode_q;
  logic [DATA_W-1:0] value_q;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [COL_W:0]    col_sum;
  logic              col_wrap, last_row, accept;

  logic [PIX_PER_BEAT-1:0][DATA_W-1:0] pix_r, pix_g, pix_b;
  logic [PIX_PER_BEAT-1:0][DATA_W-1:0] res_r, res_g, res_b;

  assign pix_r = in_r;
  assign pix_g = in_g;
  assign pix_b = in_b;

  for (genvar k = 0; k < PIX_PER_BEAT; k++) begin : g_lane
    image_pixel_op #(.DATA_W(DATA_W)) u_op (
      .in_r  (pix_r[k]),
      .in_g  (pix_g[k]),
      .in_b  (pix_b[k]),
      .mode  (mode_q),
      .value (value_q),
      .out_r (res_r[k]),
      .out_g (res_g[k]),
      .out_b (res_b[k])
    );
  end

  // Extra bit on the sum so IMG_W itself is representable at the wrap point.
  assign col_sum  = {1'b0, col} + (COL_W+1)'(PIX_PER_BEAT);
  assign col_wrap = (col_sum == (COL_W+1)'(IMG_W));
  assign last_row = (row == ROW_W'(IMG_H - 1));

  assign in_ready   = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign frame_done = (state == ST_DRAIN) && out_valid && out_ready;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)                         state_nxt = ST_RUN;
      ST_RUN:   if (accept && col_wrap && last_row) state_nxt = ST_DRAIN;
      ST_DRAIN: if (frame_done)                    state_nxt = ST_IDLE;
      default:                                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_BYPASS;
      value_q   <= '0;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        mode_q  <= mode;
        value_q <= value;
        col     <= '0;
        row     <= '0;
      end else if (accept) begin
        col <= col_wrap ? '0 : col_sum[COL_W-1:0];
        if (col_wrap) row <= last_row ? '0 : row + 1'b1;
      end
      // Single output slot: a load always wins over a drain in the same cycle.
      if (accept) begin
        out_valid <= 1'b1;
        out_r     <= res_r;
        out_g     <= res_g;
        out_b     <= res_b;
        out_sof   <= (row == '0) && (col == '0);
        out_eol   <= col_wrap;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_pixel_proc.sv
// Self-checking bench for image_pixel_proc: random and directed frames
// against a queue-based reference model of the pixel stream.
module tb_image_pixel_proc;

  localparam int PPB   = 2;
  localparam int DW    = 8;
  localparam int W     = 8;
  localparam int H     = 2;
  localparam int BEATS = W * H / PPB;
  localparam int BW    = PPB * DW;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    mode = '0;
  logic [DW-1:0] value = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_r, out_g, out_b;
  logic          out_sof, out_eol, frame_done, busy;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  image_pixel_proc #(.PIX_PER_BEAT(PPB), .DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done), .busy(busy)
  );

  typedef struct {
    logic [BW-1:0] r, g, b;
    logic          sof, eol;
    int            idx;
  } beat_t;

  beat_t         expq[$];
  logic [BW-1:0] br[BEATS], bg[BEATS], bb[BEATS];
  logic [BW-1:0] first_r, first_g, first_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int chan_op(int m, int v, int x, int lum);
    case (m)
      1:       return (x + v > 255) ? 255 : x + v;
      2:       return (x > v) ? x - v : 0;
      3:       return 255 - x;
      4:       return (lum >= v) ? 255 : 0;
      5:       return lum;
      default: return x;
    endcase
  endfunction

  function automatic beat_t model(int m, int v, int idx);
    beat_t e;
    int r, g, b, lum;
    e.r = '0; e.g = '0; e.b = '0;
    for (int k = 0; k < PPB; k++) begin
      r   = int'(br[idx][k*DW +: DW]);
      g   = int'(bg[idx][k*DW +: DW]);
      b   = int'(bb[idx][k*DW +: DW]);
      lum = (r + 2*g + b) / 4;
      e.r[k*DW +: DW] = DW'(chan_op(m, v, r, lum));
      e.g[k*DW +: DW] = DW'(chan_op(m, v, g, lum));
      e.b[k*DW +: DW] = DW'(chan_op(m, v, b, lum));
    end
    e.sof = (idx == 0);
    e.eol = (((idx + 1) * PPB) % W) == 0;
    e.idx = idx;
    return e;
  endfunction

  // kind 0: random, 1: saturation pair (0xF0, 0x10), 2: luma pattern (0x80,0x40,0x00)
  task automatic gen_data(input int kind);
    for (int i = 0; i < BEATS; i++) begin
      case (kind)
        1: begin br[i] = {8'h10, 8'hF0}; bg[i] = {8'h10, 8'hF0}; bb[i] = {8'h10, 8'hF0}; end
        2: begin br[i] = {8'h80, 8'h80}; bg[i] = {8'h40, 8'h40}; bb[i] = '0; end
        default: begin br[i] = BW'($urandom); bg[i] = BW'($urandom); bb[i] = BW'($urandom); end
      endcase
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_frame(input int m, input int v, input int ready_pct, input int kind,
                           input int reset_after, input int restart_at);
    int sent, got, cyc;
    bit hold, restarted, aborted;
    logic [BW-1:0] hr, hg, hb;
    logic hs, he;
    beat_t e;
    sent = 0; got = 0; cyc = 0; hold = 0; restarted = 0; aborted = 0;
    hr = '0; hg = '0; hb = '0; hs = 0; he = 0;
    gen_data(kind);
    expq.delete();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_r = br[0]; in_g = bg[0]; in_b = bb[0]; out_ready = 1'b1;
      @(negedge HCLK);
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
      @(posedge HCLK); #1;
    end
    start = 1'b1; mode = 3'(m); value = DW'(v); in_valid = 1'b0;
    @(posedge HCLK); #1;
    start = 1'b0;
    while (got < BEATS && cyc < 400 && !aborted) begin
      cyc++;
      if (sent < BEATS) begin
        in_valid = 1'b1; in_r = br[sent]; in_g = bg[sent]; in_b = bb[sent];
      end else begin
        in_valid = ($urandom_range(0, 1) == 1);
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (!restarted && restart_at >= 0 && sent == restart_at) begin
        start = 1'b1; mode = 3'(m + 3); value = ~DW'(v); restarted = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge HCLK);
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_r", out_r, hr);
        check("stall_g", out_g, hg);
        check("stall_b", out_b, hb);
        check("stall_sof", out_sof, hs);
        check("stall_eol", out_eol, he);
      end
      check("busy", busy, 1);
      check("in_ready", in_ready, (sent < BEATS) && (expq.size() == 0 || out_ready));
      check("out_valid", out_valid, expq.size() != 0);
      if (out_valid && out_ready && expq.size() != 0) begin
        e = expq.pop_front();
        check("out_r", out_r, e.r);
        check("out_g", out_g, e.g);
        check("out_b", out_b, e.b);
        check("out_sof", out_sof, e.sof);
        check("out_eol", out_eol, e.eol);
        check("frame_done", frame_done, e.idx == BEATS - 1);
        if (got == 0) begin first_r = out_r; first_g = out_g; first_b = out_b; end
        got++;
      end else begin
        check("frame_done_quiet", frame_done, 0);
      end
      hold = out_valid && !out_ready;
      hr = out_r; hg = out_g; hb = out_b; hs = out_sof; he = out_eol;
      if (in_valid && in_ready) begin
        expq.push_back(model(m, v, sent));
        sent++;
      end
      if (reset_after >= 0 && sent == reset_after + 1) aborted = 1;
      @(posedge HCLK); #1;
    end
    start = 1'b0;
    if (aborted) begin
      HRESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(negedge HCLK);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_data", {out_r, out_g, out_b}, 0);
      check("rst_marks", {out_sof, out_eol, frame_done}, 0);
      @(posedge HCLK); #1;
    end else begin
      check("frame_beats", got, BEATS);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge HCLK);
      check("post_busy", busy, 0);
      check("post_in_ready", in_ready, 0);
      check("post_out_valid", out_valid, 0);
      check("post_frame_done", frame_done, 0);
      @(posedge HCLK); #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int m, v;
    repeat (2) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_data", {out_r, out_g, out_b}, 0);
    check("reset_marks", {out_sof, out_eol, frame_done}, 0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    run_frame(0, 0, 100, 0, -1, -1);

    run_frame(1, 'h40, 100, 1, -1, -1);
    check("brighten_r", first_r, 16'h50FF);
    check("brighten_b", first_b, 16'h50FF);
    run_frame(2, 'h40, 100, 1, -1, -1);
    check("darken_g", first_g, 16'h00B0);

    run_frame(4, 'h40, 100, 2, -1, -1);
    check("thresh_hi", {first_r, first_g, first_b}, 48'hFFFF_FFFF_FFFF);
    run_frame(4, 'h41, 100, 2, -1, -1);
    check("thresh_lo", {first_r, first_g, first_b}, 48'h0);
    run_frame(5, 0, 100, 2, -1, -1);
    check("grey", {first_r, first_g, first_b}, 48'h4040_4040_4040);

    for (int i = 0; i < 3; i++) begin
      m = $urandom_range(0, 7);
      v = $urandom_range(0, 255);
      run_frame(m, v, 30, 0, -1, -1);
    end
    run_frame(1, 'h33, 30, 0, -1, -1);

    run_frame(3, 'h21, 70, 0, -1, 2);
    run_frame(4, 'h60, 100, 0, -1, 5);

    run_frame(0, 0, 100, 0, 3, -1);
    v = $urandom_range(0, 255);
    run_frame(2, v, 100, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
